// File: rtl/pcie_ss_axis_pkg.sv
// Shared AXI-Stream types for the PCIe SS TX path: arbiter state and source ids.
package pcie_ss_axis_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef logic src_id_t;

    localparam src_id_t SRC_TX_A = 1'b0;
    localparam src_id_t SRC_TX_B = 1'b1;

    function automatic src_id_t other_src(input src_id_t id);
        return src_id_t'(~id);
    endfunction

endpackage

// File: rtl/pcie_tx_arb_out_reg.sv
// Single-stage AXI-Stream output register; loads whenever it is empty or being drained,
// so back-to-back beats flow with no bubble.
module pcie_tx_arb_out_reg #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_keep,
    input  logic                  in_last,
    input  logic [USER_W-1:0]     in_user,
    output logic                  m_tvalid,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_W/8-1:0]   m_tkeep,
    output logic                  m_tlast,
    output logic [USER_W-1:0]     m_tuser_vendor
);

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tvalid <= in_valid;
        end
    end

    // NOTE: payload is deliberately not reset; m_tvalid alone qualifies it.
    always_ff @(posedge clk) begin
        if (load && in_valid) begin
            m_tdata        <= in_data;
            m_tkeep        <= in_keep;
            m_tlast        <= in_last;
            m_tuser_vendor <= in_user;
        end
    end

endmodule

// File: rtl/pcie_tx_pkt_arbiter.sv
// Packet-atomic weighted round-robin merge of the TX-A / TX-B streams onto the
// PCIe SS TX port through a one-beat output register.
module pcie_tx_pkt_arbiter
    import pcie_ss_axis_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int WGT_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   s_tvalid,
    output logic [1:0]                   s_tready,
    input  logic [1:0][DATA_W-1:0]       s_tdata,
    input  logic [1:0][DATA_W/8-1:0]     s_tkeep,
    input  logic [1:0]                   s_tlast,
    input  logic [1:0][USER_W-1:0]       s_tuser_vendor,
    input  logic [1:0][WGT_W-1:0]        weight,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic [USER_W-1:0]            m_tuser_vendor,
    output logic                         grant_id,
    output logic                         busy
);

    arb_state_t       state, state_nxt;
    src_id_t          ptr, grant_q, sel;
    logic [WGT_W-1:0] cnt, cnt_sat, wgt_eff;
    logic [WGT_W:0]   cnt_inc;
    logic             load, req_any, accept, accept_last;

    assign load     = !m_tvalid || m_tready;
    assign req_any  = |s_tvalid;
    assign grant_id = grant_q;

    // In IDLE the decision is made combinationally so the first beat moves this cycle.
    always_comb begin
        sel = grant_q;
        if (state == ARB_IDLE) begin
            if (&s_tvalid) begin
                sel = ptr;
            end else begin
                sel = s_tvalid[SRC_TX_B] ? SRC_TX_B : SRC_TX_A;
            end
        end
    end

    assign accept      = s_tvalid[sel] && s_tready[sel];
    assign accept_last = accept && s_tlast[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (accept && !s_tlast[sel]) state_nxt = ARB_LOCK;
            ARB_LOCK: if (accept_last)             state_nxt = ARB_IDLE;
            default:                               state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_tready = 2'b00;
        busy     = (state == ARB_LOCK);
        if (!rst && load && (state == ARB_LOCK || req_any)) begin
            s_tready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= SRC_TX_A;
        end else if (state == ARB_IDLE && accept) begin
            grant_q <= sel;
        end
    end

    // Weight is read only at tlast, so a mid-packet change waits for the next decision.
    always_comb begin
        cnt_inc = {1'b0, cnt} + {{WGT_W{1'b0}}, 1'b1};
        cnt_sat = (&cnt) ? cnt : cnt_inc[WGT_W-1:0];
        wgt_eff = (weight[sel] == '0) ? WGT_W'(1) : weight[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SRC_TX_A;
            cnt <= '0;
        end else if (accept_last) begin
            if (sel != ptr) begin
                cnt <= '0;
            end else if (s_tvalid[other_src(sel)] && ({1'b0, wgt_eff} <= cnt_inc)) begin
                ptr <= other_src(sel);
                cnt <= '0;
            end else begin
                cnt <= cnt_sat;
            end
        end
    end

    pcie_tx_arb_out_reg #(
        .DATA_W (DATA_W),
        .USER_W (USER_W)
    ) u_out_reg (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .in_valid       (accept),
        .in_data        (s_tdata[sel]),
        .in_keep        (s_tkeep[sel]),
        .in_last        (s_tlast[sel]),
        .in_user        (s_tuser_vendor[sel]),
        .m_tvalid       (m_tvalid),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tlast        (m_tlast),
        .m_tuser_vendor (m_tuser_vendor)
    );

endmodule

// File: tb/tb_pcie_tx_pkt_arbiter.sv
// Directed bench for pcie_tx_pkt_arbiter: per-source beat queues drive the inputs,
// the merged output is logged and compared against hand-written packet orders.
module tb_pcie_tx_pkt_arbiter;

    localparam int DATA_W = 512;
    localparam int USER_W = 10;
    localparam int WGT_W  = 4;
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [1:0]                 s_tvalid;
    logic [1:0]                 s_tready;
    logic [1:0][DATA_W-1:0]     s_tdata;
    logic [1:0][KEEP_W-1:0]     s_tkeep;
    logic [1:0]                 s_tlast;
    logic [1:0][USER_W-1:0]     s_tuser_vendor;
    logic [1:0][WGT_W-1:0]      weight;
    logic                       m_tvalid;
    logic                       m_tready;
    logic [DATA_W-1:0]          m_tdata;
    logic [KEEP_W-1:0]          m_tkeep;
    logic                       m_tlast;
    logic [USER_W-1:0]          m_tuser_vendor;
    logic                       grant_id;
    logic                       busy;

    always #5 clk = ~clk;

    pcie_tx_pkt_arbiter #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .WGT_W  (WGT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tlast        (s_tlast),
        .s_tuser_vendor (s_tuser_vendor),
        .weight         (weight),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tlast        (m_tlast),
        .m_tuser_vendor (m_tuser_vendor),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    // Beat encoding: {last, 4'h0, src, pkt, beat}
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] outq[$];
    logic [16:0] expq[$];
    logic [1:0]  en;
    bit          tready_toggle;
    bit          started;
    int          gaps, side_err, stable_err, busy_hi, rdy0_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] bt(input int src, input int pkt, input int beat, input bit last);
        return {last, 4'h0, 4'(src), 4'(pkt), 4'(beat)};
    endfunction

    task automatic add_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (src == 0) qa.push_back(bt(src, pkt, b, b == nbeats - 1));
            else          qb.push_back(bt(src, pkt, b, b == nbeats - 1));
        end
    endtask

    task automatic exp_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) expq.push_back(bt(src, pkt, b, b == nbeats - 1));
    endtask

    task automatic drive();
        logic [16:0] hd[2];
        bit          pr[2];
        pr[0] = qa.size() != 0;
        pr[1] = qb.size() != 0;
        hd[0] = pr[0] ? qa[0] : '0;
        hd[1] = pr[1] ? qb[0] : '0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i]       = en[i] && pr[i];
            s_tdata[i]        = DATA_W'(hd[i][15:0]);
            s_tlast[i]        = hd[i][16];
            s_tkeep[i]        = hd[i][16] ? (KEEP_ALL >> 4) : KEEP_ALL;
            s_tuser_vendor[i] = USER_W'(hd[i][15:0]);
        end
        #1;
    endtask

    task automatic tick();
        bit                fa, fb, fo, hold;
        logic [16:0]       ob;
        logic [DATA_W-1:0] held;
        fa   = s_tvalid[0] && s_tready[0];
        fb   = s_tvalid[1] && s_tready[1];
        fo   = m_tvalid && m_tready;
        ob   = {m_tlast, m_tdata[15:0]};
        hold = m_tvalid && !m_tready;
        held = m_tdata;
        if (fo) begin
            started = 1'b1;
            if (m_tuser_vendor !== USER_W'(m_tdata[15:0]) ||
                m_tkeep !== (m_tlast ? (KEEP_ALL >> 4) : KEEP_ALL)) side_err++;
        end
        if (started && !m_tvalid && (qa.size() != 0 || qb.size() != 0)) gaps++;
        if (s_tready[0] && qb.size() != 0) rdy0_bad++;
        if (busy) busy_hi++;
        @(posedge clk);
        #1;
        if (fa) void'(qa.pop_front());
        if (fb) void'(qb.pop_front());
        if (fo) outq.push_back(ob);
        if (hold && m_tdata !== held) stable_err++;
        if (tready_toggle) m_tready = ~m_tready;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 2'b00;
        m_tready = 1'b1;
        tready_toggle = 1'b0;
        qa.delete(); qb.delete(); outq.delete(); expq.delete();
        drive();
        repeat (2) tick();
        rst = 1'b0;
        drive();
        started = 1'b0;
        gaps = 0; side_err = 0; stable_err = 0; busy_hi = 0; rdy0_bad = 0;
    endtask

    task automatic run_until(input string name, input int n, input int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, " beat count"}, outq.size(), n);
    endtask

    task automatic check_seq(input string name);
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("%s[%0d]", name, i),
                  (i < outq.size()) ? {15'h0, outq[i]} : 32'hdead_beef, {15'h0, expq[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        weight = {4'd1, 4'd1};

        // Reset state
        rst = 1'b1; en = 2'b11; m_tready = 1'b1; tready_toggle = 1'b0;
        add_pkt(0, 0, 2); add_pkt(1, 0, 2);
        drive();
        tick();
        check("rst m_tvalid", m_tvalid, 0);
        check("rst s_tready", s_tready, 0);
        check("rst busy", busy, 0);
        check("rst grant_id", grant_id, 0);

        // Weight {1,1}: strict alternation, no output bubbles
        do_reset();
        weight = {4'd1, 4'd1};
        for (int p = 0; p < 4; p++) begin
            add_pkt(0, p, 3); add_pkt(1, p, 3);
            exp_pkt(0, p, 3); exp_pkt(1, p, 3);
        end
        en = 2'b11; drive();
        run_until("alt", 24, 60);
        check_seq("alt");
        check("alt gaps", gaps, 0);
        check("alt sideband", side_err, 0);

        // Weight A=3, B=1: A,A,A,B repeating
        do_reset();
        weight = {4'd1, 4'd3};
        for (int p = 0; p < 6; p++) add_pkt(0, p, 2);
        for (int p = 0; p < 2; p++) add_pkt(1, p, 2);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) exp_pkt(0, r * 3 + p, 2);
            exp_pkt(1, r, 2);
        end
        en = 2'b11; drive();
        run_until("wgt31", 16, 60);
        check_seq("wgt31");
        check("wgt31 gaps", gaps, 0);

        // B 4-beat packet, A appears on beat 2: B stays atomic, A next
        do_reset();
        weight = {4'd1, 4'd1};
        add_pkt(1, 0, 4); add_pkt(0, 0, 2);
        exp_pkt(1, 0, 4); exp_pkt(0, 0, 2);
        en = 2'b10; drive();
        for (int k = 0; k < 40 && outq.size() < 6; k++) begin
            tick();
            if (en[0] == 1'b0 && qb.size() == 3) begin
                check("lock busy", busy, 1);
                check("lock grant_id", grant_id, 1);
                en[0] = 1'b1;
                drive();
            end
        end
        check("lock beat count", outq.size(), 6);
        check_seq("lock");
        check("lock s_tready[0]", rdy0_bad, 0);

        // m_tready toggling with one source
        do_reset();
        add_pkt(0, 0, 4); exp_pkt(0, 0, 4);
        en = 2'b01; tready_toggle = 1'b1; drive();
        run_until("bp", 4, 40);
        tready_toggle = 1'b0; m_tready = 1'b1; drive();
        repeat (4) tick();
        check("bp exact count", outq.size(), 4);
        check_seq("bp");
        check("bp data stable", stable_err, 0);

        // Reset during beat 2 of a 5-beat packet
        do_reset();
        add_pkt(0, 0, 5);
        en = 2'b11; drive();
        for (int k = 0; k < 10 && qa.size() > 4; k++) tick();
        check("rst2 reached beat 2", qa.size(), 4);
        rst = 1'b1; drive();
        check("rst2 s_tready", s_tready, 0);
        tick();
        check("rst2 m_tvalid", m_tvalid, 0);
        check("rst2 busy", busy, 0);
        check("rst2 grant_id", grant_id, 0);
        rst = 1'b0; qa.delete(); outq.delete(); expq.delete();
        add_pkt(1, 1, 2); exp_pkt(1, 1, 2);
        drive();
        run_until("rst2 B", 2, 20);
        check_seq("rst2 B");
        check("rst2 B grant_id", grant_id, 1);
        outq.delete(); expq.delete();
        add_pkt(1, 2, 1); add_pkt(0, 2, 1);
        exp_pkt(0, 2, 1); exp_pkt(1, 2, 1);
        drive();
        run_until("rst2 ptr", 2, 20);
        check_seq("rst2 ptr");

        // Single-beat packets, weight 0 treated as 1
        do_reset();
        weight = {4'd0, 4'd0};
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, p, 1); add_pkt(1, p, 1);
            exp_pkt(0, p, 1); exp_pkt(1, p, 1);
        end
        en = 2'b11; drive();
        run_until("w0", 6, 30);
        check_seq("w0");
        check("w0 busy cycles", busy_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_pkt_arbiter.md
PCIE_TX_PKT_ARBITER -- requirements
Module: pcie_tx_pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 512, meaning TDATA width of all streams.
REQ-002 SHALL have parameter USER_W, default 10, meaning TUSER_VENDOR width of all streams.
REQ-003 SHALL have parameter WGT_W, default 4, meaning width of the per-source weight inputs.
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s_tvalid  in  [1:0]  per-source valid (0 = TX-A, 1 = TX-B).
- s_tready  out  [1:0]  per-source ready.
- s_tdata  in  [1:0][DATA_W]  per-source data.
- s_tkeep  in  [1:0][DATA_W/8]  per-source byte enables.
- s_tlast  in  [1:0]  per-source end of packet.
- s_tuser_vendor  in  [1:0][USER_W]  per-source user bits.
- weight  in  [1:0][WGT_W]  maximum consecutive packets per grant; 0 is treated as 1.
- m_tvalid / m_tready / m_tdata / m_tkeep / m_tlast / m_tuser_vendor  out/in/out/out/out/out  1/1/DATA_W/DATA_W/8/1/USER_W  merged output to the PCIe SS TX port.
- grant_id  out  1  source that owns the current packet.
- busy  out  1  high while a packet is in flight (state LOCK).

Function
REQ-006 SHALL merge the two sources onto m_* packet-atomically: beats of different packets never interleave.
REQ-007 SHALL implement two states: IDLE (no grant) and LOCK (grant_id owns the output until its tlast beat is accepted).
REQ-008 In IDLE with any s_tvalid, SHALL select a source in the same cycle: the only requester, or the priority pointer source if both request.
REQ-009 SHALL accept the first beat in the decision cycle when the output stage can load; SHALL then enter LOCK unless that beat carries tlast.
REQ-010 Output stage SHALL be a single register, loaded when !m_tvalid || m_tready, so full throughput is sustained with no bubble.
REQ-011 s_tready[g] SHALL equal (g selected or locked) && (!m_tvalid || m_tready); s_tready of the non-granted source SHALL be 0.
REQ-012 Latency SHALL be exactly 1 cycle from source beat acceptance to m_tvalid for that beat.
REQ-013 On acceptance of the granted source's tlast beat, SHALL return to IDLE and, in the same cycle, update the burst counter and pointer per REQ-014 and REQ-015.
REQ-014 Burst counter cnt (WGT_W bits) SHALL count packets sent consecutively by the pointer source and SHALL saturate at all-ones.
REQ-015 When the other source has s_tvalid at that tlast and cnt+1 >= max(weight[g],1), SHALL move the pointer to the other source and clear cnt; otherwise SHALL keep the pointer and increment cnt.
REQ-016 A packet granted to the non-pointer source (pointer source idle) SHALL leave the pointer unchanged and clear cnt.
REQ-017 A weight change SHALL take effect at the next tlast evaluation; a mid-packet change SHALL have no effect on the current packet.
REQ-018 Single-beat packets (tlast on the first beat) SHALL never enter LOCK.
REQ-019 A source dropping s_tvalid mid-packet SHALL keep the lock; the output SHALL stall with m_tvalid low once drained.

Reset
REQ-020 While rst is high: m_tvalid=0, s_tready=0, state=IDLE, pointer=0, cnt=0, grant_id=0, busy=0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet; the output register data is don't-care.

Structure
REQ-022 The state enum and a source-id typedef SHALL live in the shared pcie_ss_axis_pkg.
REQ-023 The output register SHALL be a sub-module, pcie_tx_arb_out_reg.

Verification
REQ-024 Bench SHALL cover the following directed scenarios:
- Both sources continuously offer 3-beat packets, weight={1,1}, m_tready=1 -> strict alternation A,B,A,B; no idle cycles on m_tvalid.
- weight[0]=3, weight[1]=1, both saturated -> packet order A,A,A,B repeating.
- B sends a 4-beat packet while A raises s_tvalid on beat 2 -> all 4 B beats are contiguous on m; A is granted next; s_tready[0]=0 throughout.
- m_tready toggling 1,0,1,0 with a single source -> every beat appears exactly once, in order; m_tdata is stable while m_tready=0.
- rst pulsed during beat 2 of a 5-beat packet -> m_tvalid=0 the next cycle; pointer=0; the next packet from B is granted normally.
- Single-beat packets on both sources with weight={0,0} -> alternation (weight 0 treated as 1); busy stays 0.
